blink_sequencer: RTL and testbench

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

---
 rtl/blink_sequencer.sv | 134 +++++++++++++
 tb/tb_blink_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sequencer.sv
// blink_sequencer: prescaled tick generator with debounced switches and four
// LED display modes (pass, blink, chase, alternate).
module blink_sequencer #(
  parameter logic [27:0] DIV = 28'd25000000,
  parameter int unsigned DEB = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic [1:0] mode_sel,
  output logic [3:0] led,
  output logic       tick,
  output logic [1:0] mode,
  output logic [3:0] sw_db
);

  typedef enum logic [1:0] {
    M_PASS  = 2'b00,
    M_BLINK = 2'b01,
    M_CHASE = 2'b10,
    M_ALT   = 2'b11
  } mode_e;

  localparam logic [3:0] DEB_L = 4'(DEB);

  logic [27:0] r_cnt;
  logic        r_tick;
  logic [3:0]  r_sw_s1;
  logic [3:0]  r_sw_s2;
  logic [1:0]  r_mode_s1;
  logic [1:0]  r_mode_s2;
  logic [3:0]  r_db_cnt [4];
  logic [3:0]  r_sw_db;
  mode_e       r_mode;
  logic        r_phase;
  logic [1:0]  r_ptr;
  logic [3:0]  r_led;
  logic [1:0]  w_first;
  logic [1:0]  w_next;
  logic [3:0]  w_led;

  // Tick is registered off the terminal count, so it lands DIV edges after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 28'd0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == DIV - 28'd1) ? 28'd0 : r_cnt + 28'd1;
      r_tick <= (r_cnt == DIV - 28'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1   <= 4'b0000;
      r_sw_s2   <= 4'b0000;
      r_mode_s1 <= 2'b00;
      r_mode_s2 <= 2'b00;
    end else begin
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      r_mode_s1 <= mode_sel;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // A channel must disagree with sw_db on DEB consecutive ticks to flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_db <= 4'b0000;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= 4'd0;
    end else if (r_tick) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sw_s2[i] != r_sw_db[i]) begin
          if (r_db_cnt[i] + 4'd1 == DEB_L) begin
            r_sw_db[i]  <= r_sw_s2[i];
            r_db_cnt[i] <= 4'd0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
          end
        end else begin
          r_db_cnt[i] <= 4'd0;
        end
      end
    end
  end

  // Descending loops let the lowest index / nearest successor win.
  always_comb begin
    w_first = 2'd0;
    w_next  = r_ptr;
    for (int i = 3; i >= 0; i--) w_first = r_sw_db[i] ? 2'(i) : w_first;
    for (int k = 3; k >= 1; k--) w_next = r_sw_db[r_ptr + 2'(k)] ? r_ptr + 2'(k) : w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= M_PASS;
      r_phase <= 1'b0;
      r_ptr   <= 2'd0;
    end else if (r_tick) begin
      if (r_mode_s2 != r_mode) begin
        r_mode  <= mode_e'(r_mode_s2);
        r_phase <= 1'b0;
        r_ptr   <= w_first;
      end else begin
        r_phase <= ~r_phase;
        if (r_mode == M_CHASE) r_ptr <= w_next;
      end
    end
  end

  always_comb begin
    w_led = 4'b0000;
    case (r_mode)
      M_PASS:  w_led = r_sw_db;
      M_BLINK: w_led = r_phase ? r_sw_db : 4'b0000;
      M_CHASE: w_led = (4'b0001 << r_ptr) & r_sw_db;
      M_ALT:   w_led = r_sw_db & (r_phase ? 4'b1010 : 4'b0101);
      default: w_led = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_led <= 4'b0000;
    else     r_led <= w_led;
  end

  assign led   = r_led;
  assign tick  = r_tick;
  assign mode  = r_mode;
  assign sw_db = r_sw_db;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: directed scenarios with literal
// expectations, then randomized stimulus compared against a behavioural model.
module tb_blink_sequencer;

  localparam int DIV = 4;
  localparam int DEB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic [1:0] mode_sel = 2'b00;
  logic [3:0] led;
  logic       tick;
  logic [1:0] mode;
  logic [3:0] sw_db;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int         m_edges = 0;
  bit         m_tick = 1'b0;
  logic [3:0] m_s1 = 4'b0000, m_s2 = 4'b0000, m_db = 4'b0000, m_led = 4'b0000;
  logic [1:0] m_ms1 = 2'b00, m_ms2 = 2'b00, m_mode = 2'b00;
  int         m_ptr = 0;
  bit         m_phase = 1'b0;
  int         m_cnt [4] = '{0, 0, 0, 0};

  blink_sequencer #(.DIV(28'(DIV)), .DEB(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode_sel(mode_sel),
    .led(led), .tick(tick), .mode(mode), .sw_db(sw_db)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] led_of(input logic [1:0] md, input bit ph, input int p,
                                        input logic [3:0] db);
    case (md)
      2'd0:    return db;
      2'd1:    return ph ? db : 4'b0000;
      2'd2:    return db[p] ? (4'b0001 << p) : 4'b0000;
      default: return db & (ph ? 4'b1010 : 4'b0101);
    endcase
  endfunction

  function automatic int first_set(input logic [3:0] db);
    for (int i = 0; i < 4; i++) if (db[i]) return i;
    return 0;
  endfunction

  function automatic int next_set(input logic [3:0] db, input int p);
    for (int k = 1; k < 4; k++) if (db[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  // Behavioural model: every rule evaluated on pre-edge values.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_edges = 0; m_tick = 1'b0; m_s1 = 4'b0000; m_s2 = 4'b0000;
      m_ms1 = 2'b00; m_ms2 = 2'b00; m_db = 4'b0000; m_mode = 2'b00;
      m_phase = 1'b0; m_ptr = 0; m_led = 4'b0000;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      bit         t;
      logic [3:0] s2, db;
      logic [1:0] ms2, md;
      bit         ph;
      int         p;
      t = m_tick; s2 = m_s2; ms2 = m_ms2; db = m_db; md = m_mode; ph = m_phase; p = m_ptr;
      m_led = led_of(md, ph, p, db);
      m_edges++;
      m_tick = ((m_edges % DIV) == 0);
      m_s2 = m_s1; m_s1 = sw; m_ms2 = m_ms1; m_ms1 = mode_sel;
      if (t) begin
        for (int c = 0; c < 4; c++) begin
          if (s2[c] != db[c]) begin
            m_cnt[c]++;
            if (m_cnt[c] == DEB) begin
              m_db[c] = s2[c];
              m_cnt[c] = 0;
            end
          end else begin
            m_cnt[c] = 0;
          end
        end
        if (ms2 != md) begin
          m_mode = ms2; m_phase = 1'b0; m_ptr = first_set(db);
        end else begin
          m_phase = !ph;
          if (md == 2'd2) m_ptr = next_set(db, p);
        end
      end
    end
  end

  // Compare process: DUT against model on every falling edge.
  initial forever begin
    @(negedge clk);
    chk("model_tick", tick, m_tick);
    chk("model_mode", mode, m_mode);
    chk("model_sw_db", sw_db, m_db);
    chk("model_led", led, m_led);
  end

  // Returns two cycles after a tick, once state and led have both settled.
  task automatic after_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tick !== 1'b1 && k < 20);
    chk("tick_seen", tick, 1'b1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) after_tick();
  endtask

  initial begin
    logic [3:0] chase_exp [4];
    chase_exp[0] = 4'b0001; chase_exp[1] = 4'b0010;
    chase_exp[2] = 4'b1000; chase_exp[3] = 4'b0001;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_led", led, 4'b0000);
    chk("rst_tick", tick, 1'b0);
    chk("rst_mode", mode, 2'b00);
    chk("rst_sw_db", sw_db, 4'b0000);

    // tick cadence after release
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("cadence_tick", tick, ((n % DIV) == 0) ? 1'b1 : 1'b0);
      chk("cadence_led", led, 4'b0000);
      chk("cadence_mode", mode, 2'b00);
    end

    // PASS
    sw = 4'b0011;
    settle(3);
    chk("pass_sw_db", sw_db, 4'b0011);
    chk("pass_led", led, 4'b0011);
    chk("pass_model_led", m_led, 4'b0011);

    // glitch on sw[2] visible for exactly one tick
    sw = 4'b0111;
    repeat (4) @(negedge clk);
    sw = 4'b0011;
    settle(3);
    chk("glitch_sw_db", sw_db, 4'b0011);
    chk("glitch_led", led, 4'b0011);

    // BLINK
    sw = 4'b1111;
    settle(3);
    chk("blink_pre_sw_db", sw_db, 4'b1111);
    mode_sel = 2'b01;
    after_tick();
    chk("blink_mode", mode, 2'b01);
    chk("blink_led0", led, 4'b0000);
    chk("blink_model_led0", m_led, 4'b0000);
    after_tick();
    chk("blink_led1", led, 4'b1111);
    after_tick();
    chk("blink_led2", led, 4'b0000);

    // CHASE over 1011
    sw = 4'b1011;
    settle(3);
    chk("chase_pre_sw_db", sw_db, 4'b1011);
    mode_sel = 2'b10;
    for (int i = 0; i < 4; i++) begin
      after_tick();
      chk("chase_led", led, chase_exp[i]);
      chk("chase_model_led", m_led, chase_exp[i]);
    end
    chk("chase_mode", mode, 2'b10);
    sw = 4'b0000;
    settle(3);
    chk("chase_off_sw_db", sw_db, 4'b0000);
    chk("chase_off_led", led, 4'b0000);

    // ALT
    sw = 4'b1111;
    settle(3);
    mode_sel = 2'b11;
    after_tick();
    chk("alt_led0", led, 4'b0101);
    after_tick();
    chk("alt_led1", led, 4'b1010);

    // asynchronous reset mid-period
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_led", led, 4'b0000);
    chk("arst_tick", tick, 1'b0);
    chk("arst_mode", mode, 2'b00);
    chk("arst_sw_db", sw_db, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= DIV; n++) begin
      @(negedge clk);
      chk("arst_tick_again", tick, (n == DIV) ? 1'b1 : 1'b0);
      chk("arst_mode_pass", mode, 2'b00);
    end

    // randomized phase, checked by the compare process
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      else if (rst) rst = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) sw = 4'($urandom);
      if ($urandom_range(0, 59) == 0) mode_sel = 2'($urandom);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
